// File: rtl/pic_interrupt_sequencer_pkg.sv
// Shared types and constants for the 8259A interrupt sequencer.
// Optional build macro: PIC_ROTATE_EN (rotating priority on non-specific EOI).
package pic_pkg;

  localparam int         IR_WIDTH     = 8;
  localparam logic [2:0] SPURIOUS_LVL = 3'd7;
  // Lowest-priority level after reset; 7 makes IR0 the highest priority.
  localparam logic [2:0] LOWEST_RESET = 3'd7;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    ACK1,
    ACK2
  } pic_state_e;

  // Priority rank of a level, 0 = highest, given the current lowest-priority level.
  function automatic logic [2:0] prio_rank(input logic [2:0] lvl, input logic [2:0] lowest);
    return lvl - lowest - 3'd1;
  endfunction

endpackage

// File: rtl/pic_interrupt_sequencer_if.sv
// CPU-side acknowledge bus of the interrupt sequencer: INTA in, INT and vector out.
// Optional build macro: PIC_ROTATE_EN (no effect on this interface).
interface pic_interrupt_sequencer_if;
  import pic_pkg::*;

  logic                inta;
  logic                int_req;
  logic [IR_WIDTH-1:0] data_out;
  logic                data_oe;

  // CPU side drives acknowledges and receives the request and vector.
  modport master (output inta, input int_req, input data_out, input data_oe);
  // PIC side receives acknowledges and drives the request and vector.
  modport slave (input inta, output int_req, output data_out, output data_oe);

endinterface

// File: rtl/pic_interrupt_sequencer_priority_resolver.sv
// Combinational priority encoder: finds the highest-priority set bit of a vector,
// where the level just after lowest_i has top priority and lowest_i has the least.
// Optional build macro: PIC_ROTATE_EN (only affects what the parent feeds into lowest_i).
module pic_priority_resolver
  import pic_pkg::*;
(
  input  logic [IR_WIDTH-1:0] vec_i,
  input  logic [2:0]          lowest_i,
  output logic                found_o,
  output logic [2:0]          lvl_o
);

  logic [2:0] idx;

  // Scan from lowest to highest priority so the last hit is the winner.
  always_comb begin
    found_o = 1'b0;
    lvl_o   = 3'd0;
    idx     = 3'd0;
    for (int i = IR_WIDTH - 1; i >= 0; i--) begin
      idx = lowest_i + 3'(i) + 3'd1;
      if (vec_i[idx]) begin
        found_o = 1'b1;
        lvl_o   = idx;
      end
    end
  end

endmodule

// File: rtl/pic_interrupt_sequencer.sv
// 8259A interrupt request/acknowledge sequencer: IRR capture, priority resolution
// against IMR/ISR, INT generation, two-pulse INTA cycle and EOI handling.
// Optional build macro: PIC_ROTATE_EN (non-specific EOI rotates priority).
module pic_interrupt_sequencer
  import pic_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [IR_WIDTH-1:0] ir_i,
  input  logic [IR_WIDTH-1:0] imr_i,
  input  logic                ltim_i,
  input  logic                aeoi_i,
  input  logic [4:0]          t7_t3_i,
  input  logic                eoi_i,
  input  logic                eoi_spec_i,
  input  logic [2:0]          eoi_lvl_i,
  output logic [IR_WIDTH-1:0] irr_o,
  output logic [IR_WIDTH-1:0] isr_o,
  pic_interrupt_sequencer_if.slave bus
);

  pic_state_e          state_q, state_d;
  logic [IR_WIDTH-1:0] irr_q, irr_d;
  logic [IR_WIDTH-1:0] isr_q, isr_d;
  logic [IR_WIDTH-1:0] ir_prev_q;
  logic [2:0]          lvl_q, lvl_d;
  logic [IR_WIDTH-1:0] data_out_q, data_out_d;
  logic                data_oe_q, data_oe_d;
  logic [2:0]          lowest;

  logic [IR_WIDTH-1:0] pending;
  logic [IR_WIDTH-1:0] isr_mid;
  logic                pend_found, isr_found;
  logic [2:0]          pend_lvl, isr_lvl;
  logic                request;
  logic                ack_first, ack_second;

`ifdef PIC_ROTATE_EN
  logic [2:0] lowest_q, lowest_d;

  // Lowest-priority pointer register, moved by non-specific EOIs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lowest_q <= LOWEST_RESET;
    else        lowest_q <= lowest_d;
  end

  // The level cleared by a non-specific EOI becomes the lowest priority.
  always_comb begin
    lowest_d = lowest_q;
    if (eoi_i && !eoi_spec_i && isr_found) lowest_d = isr_lvl;
  end

  assign lowest = lowest_q;
`else
  assign lowest = LOWEST_RESET;
`endif

  assign pending    = irr_q & ~imr_i;
  assign ack_first  = (state_q == REQ) && bus.inta;
  assign ack_second = (state_q == ACK1) && bus.inta;

  pic_priority_resolver u_pend_res (
    .vec_i    (pending),
    .lowest_i (lowest),
    .found_o  (pend_found),
    .lvl_o    (pend_lvl)
  );

  // Resolves the ISR after this cycle's INTA effects so an EOI sees them first.
  pic_priority_resolver u_isr_res (
    .vec_i    (isr_mid),
    .lowest_i (lowest),
    .found_o  (isr_found),
    .lvl_o    (isr_lvl)
  );

  assign request = pend_found &&
                   (!isr_found || (prio_rank(pend_lvl, lowest) < prio_rank(isr_lvl, lowest)));

  // ISR update from INTA (set at first pulse, auto-clear at second), then EOI clear.
  always_comb begin
    isr_mid = isr_q;
    if (ack_first && pend_found) isr_mid[pend_lvl] = 1'b1;
    if (ack_second && aeoi_i)    isr_mid[lvl_q]    = 1'b0;
    isr_d = isr_mid;
    if (eoi_i) begin
      if (eoi_spec_i)     isr_d[eoi_lvl_i] = 1'b0;
      else if (isr_found) isr_d[isr_lvl]   = 1'b0;
    end
  end

  // IRR follows IR in level mode; in edge mode it latches rising edges, and a
  // fresh edge beats the clear of the level being acknowledged.
  always_comb begin
    if (ltim_i) begin
      irr_d = ir_i;
    end else begin
      irr_d = irr_q;
      if (ack_first && pend_found) irr_d[pend_lvl] = 1'b0;
      irr_d = irr_d | (ir_i & ~ir_prev_q);
    end
  end

  // Acknowledge FSM next state, frozen level and the registered vector strobe.
  always_comb begin
    state_d    = state_q;
    lvl_d      = lvl_q;
    data_out_d = '0;
    data_oe_d  = 1'b0;
    case (state_q)
      IDLE: if (request) state_d = REQ;
      REQ: begin
        if (bus.inta) begin
          state_d = ACK1;
          lvl_d   = pend_found ? pend_lvl : SPURIOUS_LVL;
        end
      end
      ACK1: begin
        if (bus.inta) begin
          state_d    = ACK2;
          data_out_d = {t7_t3_i, lvl_q};
          data_oe_d  = 1'b1;
        end
      end
      ACK2:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // All sequencer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      irr_q      <= '0;
      isr_q      <= '0;
      ir_prev_q  <= '0;
      lvl_q      <= 3'd0;
      data_out_q <= '0;
      data_oe_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      irr_q      <= irr_d;
      isr_q      <= isr_d;
      ir_prev_q  <= ir_i;
      lvl_q      <= lvl_d;
      data_out_q <= data_out_d;
      data_oe_q  <= data_oe_d;
    end
  end

  assign bus.int_req  = (state_q == REQ);
  assign bus.data_out = data_out_q;
  assign bus.data_oe  = data_oe_q;
  assign irr_o        = irr_q;
  assign isr_o        = isr_q;

endmodule
